// File: rtl/triple_des_seq_ctrl.sv
// triple_des_seq_ctrl
// Builds a 3DES operation (EDE encrypt / DED decrypt) by running one external
// single-DES core three times, feeding each pass's output into the next pass.
// Build option: define TDES_THREE_KEY_EN to add an independent third key K3
// (three-key 3DES). Without it, K1 doubles as the third key (two-key 3DES).
module triple_des_seq_ctrl #(
  parameter int CORE_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [CORE_W-1:0] message,
  input  logic [CORE_W-1:0] K1,
  input  logic [CORE_W-1:0] K2,
`ifdef TDES_THREE_KEY_EN
  input  logic [CORE_W-1:0] K3,
`endif
  output logic              core_start,
  output logic              core_decrypt,
  output logic [CORE_W-1:0] core_key,
  output logic [CORE_W-1:0] core_din,
  input  logic [CORE_W-1:0] core_dout,
  input  logic              core_done,
  output logic              busy,
  output logic              done,
  output logic [CORE_W-1:0] result,
  input  logic [1:0]        word_sel,
  output logic [15:0]       rd_word
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t            state_q;
  logic [1:0]        pass_q;
  logic              mode_q;
  logic [CORE_W-1:0] data_q;
  logic [CORE_W-1:0] k1_q;
  logic [CORE_W-1:0] k2_q;
  logic [CORE_W-1:0] result_q;
  logic [CORE_W-1:0] core_key_q;
  logic [CORE_W-1:0] core_din_q;
  logic              core_start_q;
  logic              core_decrypt_q;
  logic              busy_q;
  logic              done_q;
  logic [15:0]       rd_word_d;

  // Third-key source: a real K3 in the three-key build, otherwise K1 again.
  logic [CORE_W-1:0] k3_in_s;
  logic [CORE_W-1:0] k3_held_s;
`ifdef TDES_THREE_KEY_EN
  logic [CORE_W-1:0] k3_q;
  assign k3_in_s   = K3;
  assign k3_held_s = k3_q;
`else
  assign k3_in_s   = K1;
  assign k3_held_s = k1_q;
`endif

  // Key for a given pass. Encrypt runs ka,kb,kc; decrypt runs kc,kb,ka.
  function automatic logic [CORE_W-1:0] pass_key(
    input logic [1:0]        p,
    input logic              m,
    input logic [CORE_W-1:0] ka,
    input logic [CORE_W-1:0] kb,
    input logic [CORE_W-1:0] kc
  );
    logic [CORE_W-1:0] k;
    case (p)
      2'd0:    k = m ? ka : kc;
      2'd1:    k = kb;
      2'd2:    k = m ? kc : ka;
      default: k = ka;
    endcase
    return k;
  endfunction

  // Core direction for a pass: outer passes follow the mode, middle pass is inverted.
  function automatic logic pass_decrypt(input logic [1:0] p, input logic m);
    return (p == 2'd1) ? m : ~m;
  endfunction

  // Control FSM: state, pass counter, latched operands and every registered output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      pass_q         <= 2'd0;
      mode_q         <= 1'b0;
      data_q         <= '0;
      k1_q           <= '0;
      k2_q           <= '0;
`ifdef TDES_THREE_KEY_EN
      k3_q           <= '0;
`endif
      result_q       <= '0;
      core_key_q     <= '0;
      core_din_q     <= '0;
      core_start_q   <= 1'b0;
      core_decrypt_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      core_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            data_q         <= message;
            k1_q           <= K1;
            k2_q           <= K2;
`ifdef TDES_THREE_KEY_EN
            k3_q           <= K3;
`endif
            mode_q         <= mode;
            pass_q         <= 2'd0;
            core_din_q     <= message;
            core_key_q     <= pass_key(2'd0, mode, K1, K2, k3_in_s);
            core_decrypt_q <= pass_decrypt(2'd0, mode);
            core_start_q   <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= ST_LAUNCH;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            busy_q  <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (core_done) begin
            data_q <= core_dout;
            busy_q <= 1'b1;
            if (pass_q == 2'd2) begin
              state_q <= ST_FINISH;
            end else begin
              // Chain this pass's output into the next pass.
              pass_q         <= pass_q + 2'd1;
              core_din_q     <= core_dout;
              core_key_q     <= pass_key(pass_q + 2'd1, mode_q, k1_q, k2_q, k3_held_s);
              core_decrypt_q <= pass_decrypt(pass_q + 2'd1, mode_q);
              core_start_q   <= 1'b1;
              state_q        <= ST_LAUNCH;
            end
          end else begin
            busy_q  <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_FINISH: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            done_q   <= 1'b1;
            result_q <= data_q;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Readback mux: word 0 is the most significant 16-bit slice of result.
  always_comb begin
    rd_word_d = 16'd0;
    case (word_sel)
      2'd0:    rd_word_d = result_q[CORE_W-1  -: 16];
      2'd1:    rd_word_d = result_q[CORE_W-17 -: 16];
      2'd2:    rd_word_d = result_q[CORE_W-33 -: 16];
      2'd3:    rd_word_d = result_q[CORE_W-49 -: 16];
      default: rd_word_d = 16'd0;
    endcase
  end

  assign core_start   = core_start_q;
  assign core_decrypt = core_decrypt_q;
  assign core_key     = core_key_q;
  assign core_din     = core_din_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign rd_word      = rd_word_d;

endmodule

// File: doc/triple_des_seq_ctrl.md
TRIPLE_DES_SEQ_CTRL -- requirements
Module: triple_des_seq_ctrl

Interface
REQ-001 SHALL provide parameter CORE_W, default 64: width of the message, key and core data paths.
REQ-002 SHALL provide port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL provide ports start (in, 1, request pulse), abort (in, 1, cancel), mode (in, 1, 1=encrypt EDE, 0=decrypt DED).
REQ-005 SHALL provide ports message, K1, K2 (in, CORE_W each): operand and keys, sampled only when a start is accepted.
REQ-006 SHALL provide core-side ports: core_start (out, 1), core_decrypt (out, 1), core_key (out, CORE_W), core_din (out, CORE_W), core_dout (in, CORE_W), core_done (in, 1).
REQ-007 SHALL provide ports busy (out, 1), done (out, 1, one-cycle pulse), result (out, CORE_W), word_sel (in, 2), rd_word (out, 16).

Function
REQ-008 SHALL time-share one external single-DES core across three passes; FSM states IDLE, LAUNCH, WAIT, FINISH; a 2-bit pass counter takes values 0..2.
REQ-009 IDLE: start=1 with abort=0 SHALL latch message into data_reg, latch the keys and mode, clear pass to 0, and go to LAUNCH; busy=0 only in IDLE.
REQ-010 LAUNCH SHALL hold core_start=1 for exactly one cycle, then go to WAIT; core_start SHALL be 0 in all other states.
REQ-011 core_din, core_key and core_decrypt SHALL be driven from registers and stay stable from LAUNCH until the core_done for that pass.
REQ-012 Pass schedule for mode=1: pass0 encrypt K1, pass1 decrypt K2, pass2 encrypt K1. Pass schedule for mode=0: pass0 decrypt K1, pass1 encrypt K2, pass2 decrypt K1.
REQ-013 WAIT: core_done=1 SHALL load core_dout into data_reg. If pass<2, increment pass and go to LAUNCH; if pass=2, go to FINISH.
REQ-014 core_done SHALL be ignored in IDLE, LAUNCH and FINISH; the core response latency is unbounded and the FSM waits indefinitely.
REQ-015 FINISH SHALL assert done=1 for one cycle, copy data_reg to result, and return to IDLE; result holds until the next FINISH.
REQ-016 start while busy=1 SHALL be ignored and not queued; start in the FINISH cycle is ignored.
REQ-017 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no done pulse and result unchanged; abort beats start in the same cycle.
REQ-018 rd_word SHALL be combinational from result: word_sel 0 gives bits [CORE_W-1 -: 16], then consecutive 16-bit slices toward the LSB, with 3 giving the least significant slice.
REQ-019 Latency with core latency L (core_done L cycles after core_start) SHALL be 3*(L+1)+1 cycles from the start-accept edge to the done edge.

Reset
REQ-020 rst_n=0 at a rising edge SHALL force IDLE with busy=0, done=0, core_start=0, core_decrypt=0, pass=0, and result, data_reg, core_din, core_key all 0.
REQ-021 Reset mid-operation SHALL discard the transfer; any late core_done after reset SHALL be ignored.

Configuration
REQ-022 With macro TDES_THREE_KEY_EN defined, the block SHALL add input K3 (CORE_W), latched with the other keys at start.
REQ-023 With TDES_THREE_KEY_EN defined, the schedule SHALL be: mode=1 E(K1), D(K2), E(K3); mode=0 D(K3), E(K2), D(K1).
REQ-024 Without TDES_THREE_KEY_EN, K3 SHALL not exist and REQ-012 applies.

Verification
REQ-025 Bench core model (L=16), K1=K2=133457799BBCDFF1, message=0123456789ABCDEF, mode=1 -> result=85E813540F0AB405, done exactly 52 cycles after the start edge.
REQ-026 Same keys, message=85E813540F0AB405, mode=0 -> result=0123456789ABCDEF; rd_word for word_sel 0..3 = 0123, 4567, 89AB, CDEF.
REQ-027 start pulsed every cycle during a transfer -> exactly one done, and exactly 3 core_start pulses with decrypt sequence 0,1,0.
REQ-028 abort during the second WAIT -> IDLE next cycle, no done, result retains its prior value; a following start completes normally.
REQ-029 rst_n=0 for one cycle during pass 1, then core_done injected -> outputs at reset values, no core_start, no done.
REQ-030 With TDES_THREE_KEY_EN defined, K1, K2, K3 all distinct -> core_key sequence K1, K2, K3 for mode=1 and K3, K2, K1 for mode=0, with round-trip recovering the message.
